// File: rtl/dpwm_pkg.sv
// dpwm_pkg: shared constants, count-direction type and duty arithmetic helpers
//   STEP_FINE  duty step used when OPCION=0
//   dir_t      triangle-counter direction (center-aligned build only)
//   chan_bits  width of a channel index, never below 1
//   sat_step   saturating add/subtract clamped to [0, lim]
package dpwm_pkg;
  localparam int unsigned STEP_FINE = 1;
  typedef enum logic {UP, DOWN} dir_t;
  function automatic int chan_bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int unsigned sat_step(input int unsigned v, s, lim, input logic inc);
    return inc ? (v + s > lim ? lim : v + s) : (v < s ? 32'd0 : v - s);
  endfunction
endpackage

// File: rtl/dpwm_multi_channel_if.sv
// dpwm_multi_channel_if: button/selection inputs and PWM/status outputs of the DPWM
//   AUMENTO, DISMINUCION  increase/decrease requests (async levels)
//   OPCION, CANAL         step select and edited channel
//   PWM, DUTY_SEL         PWM outputs and shadow duty of CANAL
//   PERIOD_START          pulse on the shadow->active load cycle
//   master drives requests, slave is the generator
interface dpwm_multi_channel_if import dpwm_pkg::*; #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 8
);
  localparam int CW = chan_bits(CHANNELS);
  logic AUMENTO;
  logic DISMINUCION;
  logic OPCION;
  logic [CW-1:0] CANAL;
  logic [CHANNELS-1:0] PWM;
  logic [WIDTH:0] DUTY_SEL;
  logic PERIOD_START;
  modport master(output AUMENTO, DISMINUCION, OPCION, CANAL, input PWM, DUTY_SEL, PERIOD_START);
  modport slave(input AUMENTO, DISMINUCION, OPCION, CANAL, output PWM, DUTY_SEL, PERIOD_START);
endinterface

// File: rtl/dpwm_edge_sync.sv
// dpwm_edge_sync: 2-FF synchroniser plus rising-edge detector
//   clk, rst  clock and async active-high reset
//   d         asynchronous level input
//   pulse     one-cycle pulse two cycles after d rises
module dpwm_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic [2:0] s;
  always_ff @(posedge clk or posedge rst)
    if (rst) s <= '0;
    else s <= {s[1:0], d};
  assign pulse = s[1] & ~s[2];
endmodule

// File: rtl/dpwm_multi_channel.sv
// dpwm_multi_channel: multi-channel DPWM with double-buffered, button-edited duties
//   CLOCK_NEXYS, RST  clock and async active-high reset
//   bus (slave)       requests in; PWM, DUTY_SEL, PERIOD_START out
//   DPWM_CENTER_ALIGNED_EN selects a triangle counter instead of the sawtooth
module dpwm_multi_channel import dpwm_pkg::*; #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 8,
  parameter int DIV = 4,
  parameter int unsigned STEP_COARSE = 16
) (
  input logic CLOCK_NEXYS,
  input logic RST,
  dpwm_multi_channel_if.slave bus
);
  localparam int CW = chan_bits(CHANNELS);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int DW = WIDTH + 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] CMAX = '1;
  localparam logic [WIDTH:0] FULL = {1'b1, {WIDTH{1'b0}}};
  localparam logic [CW:0] NCH = (CW + 1)'(CHANNELS);
  logic [PW-1:0] pre;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH:0] sh [CHANNELS];
  logic [WIDTH:0] act [CHANNELS];
  logic [WIDTH:0] duty_sel, nxt;
  logic [CHANNELS-1:0] pwm, on;
  logic up_p, dn_p, tick, boundary, sel_ok, edit;
  int unsigned step;
  dpwm_edge_sync u_up (.clk(CLOCK_NEXYS), .rst(RST), .d(bus.AUMENTO), .pulse(up_p));
  dpwm_edge_sync u_dn (.clk(CLOCK_NEXYS), .rst(RST), .d(bus.DISMINUCION), .pulse(dn_p));
  assign tick = pre == PMAX;
  assign sel_ok = {1'b0, bus.CANAL} < NCH;
  assign duty_sel = sel_ok ? sh[bus.CANAL] : '0;
  assign step = bus.OPCION ? STEP_COARSE : STEP_FINE;
  // Simultaneous increase and decrease edges cancel out.
  assign edit = (up_p ^ dn_p) & sel_ok;
  assign nxt = DW'(sat_step(32'(duty_sel), step, 32'(FULL), up_p));
  assign bus.DUTY_SEL = duty_sel;
  assign bus.PWM = pwm;
  assign bus.PERIOD_START = boundary;
  always_ff @(posedge CLOCK_NEXYS or posedge RST)
    if (RST) pre <= '0;
    else pre <= tick ? '0 : pre + 1'b1;
`ifdef DPWM_CENTER_ALIGNED_EN
  dir_t dir;
  // Boundary is the down-count tick that lands on zero.
  assign boundary = tick && dir == DOWN && cnt == WIDTH'(1);
  always_ff @(posedge CLOCK_NEXYS or posedge RST)
    if (RST) begin
      cnt <= '0;
      dir <= UP;
    end else if (tick) begin
      if (dir == UP) begin
        cnt <= cnt == CMAX ? cnt - 1'b1 : cnt + 1'b1;
        dir <= cnt == CMAX ? DOWN : UP;
      end else begin
        cnt <= cnt - 1'b1;
        dir <= cnt == WIDTH'(1) ? UP : DOWN;
      end
    end
  // High band sits around the peak so the pulse is centred on cnt = 2^WIDTH-1.
  always_comb begin
    on = '0;
    for (int c = 0; c < CHANNELS; c++) on[c] = {1'b0, cnt} >= FULL - act[c];
  end
`else
  assign boundary = tick && cnt == CMAX;
  always_ff @(posedge CLOCK_NEXYS or posedge RST)
    if (RST) cnt <= '0;
    else if (tick) cnt <= cnt + 1'b1;
  always_comb begin
    on = '0;
    for (int c = 0; c < CHANNELS; c++) on[c] = {1'b0, cnt} < act[c];
  end
`endif
  // Shadow written this cycle misses a coincident load; act sees the old sh.
  always_ff @(posedge CLOCK_NEXYS or posedge RST)
    if (RST) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sh[c] <= '0;
        act[c] <= '0;
      end
      pwm <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++)
        if (boundary) act[c] <= sh[c];
      pwm <= on;
      if (edit) sh[bus.CANAL] <= nxt;
    end
endmodule

// File: tb/tb_dpwm_multi_channel.sv
// tb_dpwm_multi_channel: scoreboard bench for dpwm_multi_channel (WIDTH=4, DIV=1, CHANNELS=2)
module tb_dpwm_multi_channel;
  localparam int W = 4;
  localparam int CH = 2;
`ifdef DPWM_CENTER_ALIGNED_EN
  localparam int PERIOD = 30;
`else
  localparam int PERIOD = 16;
`endif
  typedef struct {int v; int at;} dexp_t;
  typedef struct {int h0; int h1;} wexp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  dexp_t qd[$];
  wexp_t qw[$];
  int nchk = 0, nfail = 0, cyc = 0, rel_cyc = 0, last_ps = -1, h0 = 0, h1 = 0, prev_duty = 0;
  bit ps_d = 1'b0;
  always #5 clk = ~clk;
  dpwm_multi_channel_if #(.CHANNELS(CH), .WIDTH(W)) bus ();
  dpwm_multi_channel #(.CHANNELS(CH), .WIDTH(W), .DIV(1), .STEP_COARSE(16)) dut (
    .CLOCK_NEXYS(clk),
    .RST(rst),
    .bus(bus)
  );
  task automatic check(input string nm, input int a, input int e);
    nchk++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, a, e, $time);
    end
  endtask
  function automatic int hi(input int d);
`ifdef DPWM_CENTER_ALIGNED_EN
    return d == 0 ? 0 : d >= 16 ? 30 : 2 * d - 1;
`else
    return d;
`endif
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (int'(bus.DUTY_SEL) != prev_duty) begin
      if (qd.size() == 0) check("duty_unexpected_change", int'(bus.DUTY_SEL), prev_duty);
      else begin
        dexp_t e;
        e = qd.pop_front();
        check("duty_sel", int'(bus.DUTY_SEL), e.v);
        if (e.at >= 0) check("duty_latency", cyc, e.at);
      end
      prev_duty = int'(bus.DUTY_SEL);
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      h0 = 0;
      h1 = 0;
      ps_d = 1'b0;
      last_ps = -1;
    end else begin
      h0 += int'(bus.PWM[0]);
      h1 += int'(bus.PWM[1]);
      if (ps_d) begin
        if (qw.size() > 0) begin
          wexp_t e;
          e = qw.pop_front();
          check("pwm0_high_cycles", h0, e.h0);
          check("pwm1_high_cycles", h1, e.h1);
        end
        h0 = 0;
        h1 = 0;
      end
      if (bus.PERIOD_START) begin
        check("period_start_spacing", cyc - (last_ps < 0 ? rel_cyc : last_ps), last_ps < 0 ? PERIOD - 1 : PERIOD);
        last_ps = cyc;
      end
      ps_d = bus.PERIOD_START;
    end
  end
  task automatic wait_ps();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.PERIOD_START && n < 200);
    if (!bus.PERIOD_START) begin
      nchk++;
      nfail++;
      $display("FAIL period_start_timeout: got none in %0d cycles, expected a pulse", n);
    end
  endtask
  task automatic window(input int d0, input int d1);
    int n = 0;
    wait_ps();
    repeat (2) @(posedge clk);
    qw.push_back('{hi(d0), hi(d1)});
    while (qw.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (qw.size() > 0) begin
      nchk++;
      nfail++;
      $display("FAIL window_timeout: got %0d pending windows, expected 0", qw.size());
      qw.delete();
    end
  endtask
  task automatic press(input bit up, input bit dn, input int hold, input int e);
    @(posedge clk);
    #1;
    if (e >= 0) qd.push_back('{e, cyc + 3});
    bus.AUMENTO = up;
    bus.DISMINUCION = dn;
    repeat (hold) @(posedge clk);
    #1;
    bus.AUMENTO = 1'b0;
    bus.DISMINUCION = 1'b0;
    repeat (8) @(posedge clk);
  endtask
  task automatic set_sel(input bit opt, input bit ch, input int e);
    @(posedge clk);
    #1;
    if (e >= 0) qd.push_back('{e, cyc});
    bus.OPCION = opt;
    bus.CANAL = ch;
  endtask
  initial begin
    bus.AUMENTO = 1'b0;
    bus.DISMINUCION = 1'b0;
    bus.OPCION = 1'b0;
    bus.CANAL = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_pwm", int'(bus.PWM), 0);
      check("rst_duty_sel", int'(bus.DUTY_SEL), 0);
      check("rst_period_start", int'(bus.PERIOD_START), 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    rel_cyc = cyc;
    window(0, 0);
    for (int i = 1; i <= 3; i++) press(1'b1, 1'b0, 100, i);
    window(3, 0);
    set_sel(1'b1, 1'b1, 0);
    press(1'b1, 1'b0, 6, 16);
    press(1'b1, 1'b0, 6, -1);
    check("sat_high", int'(bus.DUTY_SEL), 16);
    window(3, 16);
    set_sel(1'b0, 1'b1, -1);
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 6, 15 - i);
    press(1'b1, 1'b1, 6, -1);
    check("both_edges_no_change", int'(bus.DUTY_SEL), 13);
    set_sel(1'b1, 1'b1, -1);
    press(1'b0, 1'b1, 6, 0);
    press(1'b0, 1'b1, 6, -1);
    check("sat_low", int'(bus.DUTY_SEL), 0);
    set_sel(1'b0, 1'b0, 3);
    for (int i = 4; i <= 8; i++) press(1'b1, 1'b0, 6, i);
    window(8, 0);
    wait_ps();
    repeat (PERIOD / 2) @(posedge clk);
    #3;
    check("pwm_before_reset", int'(bus.PWM), 1);
    qd.push_back('{0, -1});
    rst = 1'b1;
    #1;
    check("pwm_async_reset", int'(bus.PWM), 0);
    check("period_start_in_reset", int'(bus.PERIOD_START), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rel_cyc = cyc;
    window(0, 0);
    repeat (4) @(negedge clk);
    check("duty_queue_drained", qd.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/dpwm_multi_channel.md
# dpwm_multi_channel

Parametrised multi-channel digital PWM generator, successor to the single-channel DPWM on the Nexys board. Push-button pulses on AUMENTO/DISMINUCION adjust the duty of the channel chosen by CANAL; OPCION selects fine or coarse step. Duty changes are double-buffered and take effect only at a period boundary, so they never glitch. The duty of the selected channel is exported for the existing 7-segment display path.

## Interface
- CHANNELS, 4: number of independent PWM outputs (1..16)
- WIDTH, 8: counter resolution in bits; duty range 0..2^WIDTH
- DIV, 4: clock cycles per counter tick (≥1)
- STEP_COARSE, 16: duty step when OPCION=1 (1..2^WIDTH)
- CLOCK_NEXYS  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- AUMENTO  in  1  increase request, asynchronous level; acts on rising edge
- DISMINUCION  in  1  decrease request, asynchronous level; acts on rising edge
- OPCION  in  1  step select: 0 → step 1, 1 → STEP_COARSE
- CANAL  in  max(1,$clog2(CHANNELS))  channel edited by requests and shown on DUTY_SEL
- PWM  out  CHANNELS  registered PWM outputs
- DUTY_SEL  out  WIDTH+1  shadow duty of channel CANAL
- PERIOD_START  out  1  one-cycle pulse on the cycle shadow duties are loaded into active duties

## Operation
- Prescaler counts 0..DIV-1; tick asserted when it wraps. Period counter cnt (WIDTH bits) advances one per tick, wraps 2^WIDTH-1 → 0.
- Per channel: shadow duty sh[c] and active duty act[c], both WIDTH+1 bits.
- PWM[c] registered: 1 when cnt < act[c]. Duty 0 → constant 0; duty 2^WIDTH → constant 1.
- Period boundary is the tick on which cnt wraps to 0. On that cycle all act[c] ← sh[c] and PERIOD_START = 1.
- AUMENTO and DISMINUCION each pass a 2-FF synchroniser, then rising-edge detection. A held button gives exactly one step.
- On an edge, sh[CANAL] ± step. The increase saturates at 2^WIDTH and the decrease saturates at 0. There is no wrap-around.
- Increase and decrease edges in the same cycle: no change.
- CANAL ≥ CHANNELS: request ignored; DUTY_SEL = 0.
- OPCION and CANAL are sampled in the edge cycle only.
- DUTY_SEL is a combinational mux of sh[] on CANAL.

## Timing
- Reset (asynchronous, immediate): PWM = 0, DUTY_SEL = 0, PERIOD_START = 0, cnt = 0, prescaler = 0, all sh/act = 0, synchroniser flops = 0.
- Request latency: input rises in cycle n, edge is detected in n+2, sh updated and visible on DUTY_SEL in n+3.
- A shadow update in the same cycle as the boundary load is not taken in that load. It is applied at the following boundary.
- PWM lags cnt by one clock. Period = DIV·2^WIDTH clocks (edge-aligned).
- Reset mid-period clears everything. After release, the first tick occurs DIV cycles later.

## Configuration
- DPWM_CENTER_ALIGNED_EN defined:
  - cnt counts up 0 → 2^WIDTH-1, then down to 0 (triangle).
  - Period = DIV·(2^(WIDTH+1)-2) clocks.
  - The boundary is the tick on which cnt reaches 0 while counting down.
  - Output is symmetric about the peak. Duty 2^WIDTH → constant 1; duty 0 → constant 0.
- Undefined: edge-aligned sawtooth as in Operation. The direction flop and its logic are absent.

## Structure
- Package dpwm_pkg holds:
  - step constants (STEP_FINE = 1)
  - count-direction enum (UP, DOWN)
  - helper function for saturating add/subtract of WIDTH+1-bit values
- Sub-module dpwm_edge_sync contains the 2-FF synchroniser and rising-edge pulse. It is instantiated for AUMENTO and DISMINUCION.
- The top level holds the prescaler, counter, shadow/active arrays and comparators.

## Test plan
- Reset with WIDTH=4, DIV=1, CHANNELS=2:
  - all outputs 0 during reset
  - after release, PERIOD_START pulses every 16 cycles and PWM stays 0.
- CANAL=0, OPCION=0, three AUMENTO presses of 100 cycles each:
  - DUTY_SEL = 3 three cycles after the last edge
  - after the next PERIOD_START, PWM[0] is high for 3 of every 16 cycles
  - PWM[1] stays 0.
- OPCION=1 (STEP_COARSE=16), CANAL=1, two AUMENTO presses:
  - DUTY_SEL saturates at 16
  - PWM[1] is constant 1 after the boundary.
- Then three DISMINUCION presses with OPCION=0:
  - DUTY_SEL = 13.
- AUMENTO and DISMINUCION rise in the same cycle:
  - DUTY_SEL is unchanged.
- RST asserted mid-period with duty 8:
  - PWM drops to 0 asynchronously and DUTY_SEL = 0
  - with DPWM_CENTER_ALIGNED_EN defined and duty 8, PWM high for 15 of every 30 cycles, centred on cnt = 15.
